// File: rtl/codificador_pkg.sv
// Shared types and helpers for the push-button encoder.
package codificador_pkg;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD} estado_t;

  localparam int NUM_BOTONES = 4;

  function automatic logic [1:0] onehot_a_bin(input logic [3:0] pat);
    logic [1:0] idx;
    case (pat)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic es_onehot(input logic [3:0] pat);
    return (pat != 4'd0) && ((pat & (pat - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/codificador_botones_sincronizador.sv
// Multi-stage flop synchronizer for asynchronous board inputs.
// Each bit is synchronized independently; no bus coherency is implied.
module sincronizador #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] etapa_q;
  logic [STAGES-1:0][WIDTH-1:0] etapa_d;

  always_comb begin
    etapa_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      etapa_d[i] = etapa_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      etapa_q <= '0;
    end else begin
      etapa_q <= etapa_d;
    end
  end

  assign dout = etapa_q[STAGES-1];

endmodule

// File: rtl/codificador_botones.sv
// Encodes four debounced push-buttons into a 2-bit value with a one-cycle
// valid strobe; stable multi-button presses yield a one-cycle conflict strobe.
module codificador_botones
  import codificador_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BOTONES-1:0] btn,
  output logic [1:0]             valor,
  output logic                   valido,
  output logic                   conflicto
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [NUM_BOTONES-1:0] btn_s;

  sincronizador #(
    .WIDTH (NUM_BOTONES),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (btn),
    .dout (btn_s)
  );

  estado_t                estado_q, estado_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_BOTONES-1:0] pat_q, pat_d;
  logic [1:0]             valor_q, valor_d;
  logic                   valido_q, valido_d;
  logic                   conflicto_q, conflicto_d;

  always_comb begin
    estado_d    = estado_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    valor_d     = valor_q;
    valido_d    = 1'b0;
    conflicto_d = 1'b0;

    case (estado_q)
      IDLE: begin
        cnt_d = '0;
        if (btn_s != '0) begin
          pat_d    = btn_s;
          cnt_d    = CNT_ONE;
          estado_d = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        // Any change, including a release, restarts qualification from IDLE.
        if (btn_s != pat_q) begin
          cnt_d    = '0;
          estado_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          if (es_onehot(pat_q)) begin
            valor_d  = onehot_a_bin(pat_q);
            valido_d = 1'b1;
          end else begin
            conflicto_d = 1'b1;
          end
          cnt_d    = '0;
          estado_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      HOLD: begin
        // Only a debounced all-released bus re-arms; other activity is ignored.
        if (btn_s != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d    = '0;
          estado_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        cnt_d    = '0;
        estado_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= IDLE;
      cnt_q       <= '0;
      pat_q       <= '0;
      valor_q     <= 2'b00;
      valido_q    <= 1'b0;
      conflicto_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      valor_q     <= valor_d;
      valido_q    <= valido_d;
      conflicto_q <= conflicto_d;
    end
  end

  assign valor     = valor_q;
  assign valido    = valido_q;
  assign conflicto = conflicto_q;

endmodule

// File: doc/codificador_botones.md
Name: codificador_botones

Overview:
- Input-side counterpart of the one-hot LED display path: four raw push-buttons (one per value 0..3) are encoded into the 2-bit state valor (C_D) that the LED visualizer decodes.
- Synchronizes and debounces the buttons, requires a clean one-hot press, and emits a registered 2-bit value with a single-cycle valid strobe.
- Multi-button presses are reported as a conflict.
- Sits between board push-buttons and the accumulated-state logic / LED visualizer.

Parameters:
- SYNC_STAGES, 2: flip-flop stages in the input synchronizer; minimum 2.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized cycles required to accept a press or a release; minimum 2. Counter width is $clog2(DEBOUNCE_CYCLES).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn  input  4  raw asynchronous buttons, active-high; btn[i] requests value i.
- valor  output  2  last accepted value, registered, held between presses.
- valido  output  1  one-cycle pulse when valor is updated.
- conflicto  output  1  one-cycle pulse when a stable multi-bit pattern is rejected.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous release through normal flops): valor=2'b00, valido=0, conflicto=0, FSM=IDLE, counter=0, synchronizer flops=0, captured pattern=0.
- Synchronizer: btn passes through SYNC_STAGES flops per bit. The resulting bus is btn_s; all logic below uses btn_s only.
- FSM states: IDLE, DEBOUNCE, HOLD.
- IDLE:
  - btn_s==0: stay in IDLE.
  - btn_s!=0: capture pat<=btn_s, cnt<=1, go to DEBOUNCE.
- DEBOUNCE:
  - btn_s!=pat (includes all-zero): go to IDLE, counter cleared, no output event.
  - btn_s==pat and cnt<DEBOUNCE_CYCLES-1: cnt++.
  - btn_s==pat and cnt==DEBOUNCE_CYCLES-1: commit.
    - If pat is one-hot, then on that edge valor<=index(pat) and valido<=1.
    - Otherwise conflicto<=1 and valor is unchanged.
    - In both cases cnt<=0 and FSM goes to HOLD.
- HOLD (waits for a debounced release):
  - btn_s==0: cnt++. When cnt reaches DEBOUNCE_CYCLES-1 with btn_s==0, go to IDLE.
  - btn_s!=0: cnt<=0, stay in HOLD. Pattern changes or extra buttons during HOLD are ignored and generate no events.
- Strobes: valido and conflicto are high for exactly one cycle and never high simultaneously. A held button produces exactly one event.
- Latency: a clean raw press stable from cycle 0 produces valido high in cycle SYNC_STAGES+DEBOUNCE_CYCLES (18 with defaults). valor changes in the same cycle that valido is high.
- Re-pressing the same value still produces a valido pulse; valor is rewritten with the same value.
- Bounce shorter than DEBOUNCE_CYCLES produces no event. Each change of btn_s restarts qualification.
- Reset mid-operation: all state returns to reset values immediately. A press in progress is discarded, and no strobe is issued after reset release until a full new qualification completes.
- Encoding: 0001->00, 0010->01, 0100->10, 1000->11. Any other nonzero pattern is a conflict.

Decomposition:
- Shared package codificador_pkg holds:
  - typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD} estado_t;
  - localparam NUM_BOTONES=4;
  - function onehot_a_bin(logic [3:0]) returning logic [1:0];
  - function es_onehot(logic [3:0]) returning logic.
- Sub-module sincronizador (parameterized WIDTH and STAGES, async active-low reset): instantiated once for the 4-bit btn bus. It is reusable for other asynchronous board inputs.
- FSM, counter and output registers are in the top module.

Test Plan:
- Reset with btn=0000 held for 10 cycles -> valor=00, valido=0, conflicto=0 throughout. Assert rst_n mid-cycle -> outputs clear without waiting for a clock edge.
- DEBOUNCE_CYCLES=4, SYNC_STAGES=2: btn=0100 from cycle 0, held -> single valido pulse at cycle 6, valor=10 from cycle 6, no further pulses while held.
- btn[1] toggling every 2 cycles for 20 cycles, then stable high -> no event during bouncing, exactly one valido pulse, valor=01.
- btn=1001 held stable -> one conflicto pulse after qualification, valor keeps its prior value, valido stays 0. After release and a press of btn=1000 -> valido pulse, valor=11.
- Hold btn=0001 (valor=00 accepted), add btn[2] while holding, then release to 0000 with a 2-cycle glitch -> no event during HOLD. Then press 0100 after a stable release -> valor=10.
- Press btn=0010 and assert rst_n low at cnt=2 in DEBOUNCE, release reset with the button still held -> valor=00 during reset, one valido pulse (valor=01) SYNC_STAGES+DEBOUNCE_CYCLES cycles after reset release, none before.
